tx_fifo_rd_stage: RTL and testbench



---
 rtl/tx_fifo_rd_stage_pkg.sv | 18 +
 rtl/tx_rd_skid_buf.sv | 53 +++++
 rtl/tx_fifo_rd_stage.sv | 67 ++++++
 tb/tb_tx_fifo_rd_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_rd_stage_pkg.sv
// Shared TX read-side definitions.
//   TX_DATA_WIDTH   : default FIFO word width
//   TX_RD_BUF_DEPTH : output buffer depth, also the credit limit for rinc
//   tx_rd_used()    : slots committed after this cycle (count + inflight - pop)
package tx_fifo_rd_stage_pkg;

    localparam int TX_DATA_WIDTH   = 32;
    localparam int TX_RD_BUF_DEPTH = 2;

    // 3-bit so count + inflight never overflows. pop implies count >= 1,
    // so the subtraction never underflows.
    function automatic logic [2:0] tx_rd_used(input logic [1:0] cnt,
                                              input logic       infl,
                                              input logic       pop);
        return {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/tx_rd_skid_buf.sv
// 2-entry circular output buffer for the TX FIFO read stage.
//   clk, rst_n : read-domain clock, async active-low reset
//   wr_en      : store wr_data at the tail
//   wr_data    : word returned by the FIFO memory
//   rd_en      : drop the head word (downstream accepted it)
//   rd_data    : head word
//   count      : occupancy, 0..2
module tx_rd_skid_buf
    import tx_fifo_rd_stage_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] r_entry [0:1];
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (wr_en) begin
                r_entry[r_tail] <= wr_data;
                r_tail          <= ~r_tail;
            end
            if (rd_en)
                r_head <= ~r_head;
            // Write and read together leave the occupancy unchanged.
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_entry[r_head];
    assign count   = r_count;

endmodule

// File: rtl/tx_fifo_rd_stage.sv
// TX async FIFO read-side consumer stage.
// Issues rinc pops, absorbs the 1-cycle memory read latency and presents
// words on a valid/ready handshake through a 2-entry buffer.
//   r_clk, rrst_n : read-domain clock, async active-low reset
//   rempty        : FIFO empty flag
//   r_data        : memory read data, valid the cycle after rinc
//   out_ready     : downstream accepts out_data
//   rinc          : pop request to the read-pointer block
//   out_valid     : out_data holds a valid word
//   out_data      : head word of the buffer
//   out_level     : buffer occupancy, 0..2
module tx_fifo_rd_stage
    import tx_fifo_rd_stage_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  out_ready,
    output logic                  rinc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_level
);

    logic                  r_inflight;
    logic                  w_pop;
    logic                  w_rinc;
    logic [2:0]            w_used;
    logic [1:0]            w_count;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_pop  = out_valid & out_ready;
    // Credit: only pop if the word will have a slot when it lands. Counting
    // this cycle's pop (combinational from out_ready) is what allows one
    // word per cycle with a 2-deep buffer.
    assign w_used = tx_rd_used(w_count, r_inflight, w_pop);
    assign w_rinc = rrst_n & ~rempty & (w_used < 3'(TX_RD_BUF_DEPTH));
    assign rinc   = w_rinc;

    // A read issued this cycle returns data next cycle.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n)
            r_inflight <= 1'b0;
        else
            r_inflight <= w_rinc;
    end

    tx_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (r_clk),
        .rst_n   (rrst_n),
        .wr_en   (r_inflight),
        .wr_data (r_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .count   (w_count)
    );

    assign out_valid = (w_count != 2'd0);
    assign out_data  = w_rd_data;
    assign out_level = w_count;

endmodule

// File: tb/tb_tx_fifo_rd_stage.sv
module tb_tx_fifo_rd_stage;

    logic        r_clk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [31:0] r_data;
    logic        out_ready;
    logic        rinc;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_level;

    tx_fifo_rd_stage #(.DATA_WIDTH(32)) dut (
        .r_clk     (r_clk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .r_data    (r_data),
        .out_ready (out_ready),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_level (out_level)
    );

    always #5 r_clk = ~r_clk;

    // Never pop an empty FIFO; never commit more than the buffer can hold.
    a_no_rinc_empty: assert property (@(posedge r_clk) disable iff (!rrst_n) rempty |-> !rinc)
        else $error("rinc asserted while rempty");
    a_credit: assert property (@(posedge r_clk) disable iff (!rrst_n)
                               ({1'b0, out_level} + {2'b00, dut.r_inflight}) <= 3'd2)
        else $error("count + inflight exceeds 2");

    int n_chk = 0;
    int n_err = 0;

    // Reference: FIFO contents, words sent in order, buffered words, in-flight flag.
    logic [31:0] fifo [$];
    logic [31:0] sent [$];
    logic [31:0] mbuf [$];
    bit          m_infl;

    logic        last_rinc;
    logic        last_valid;
    logic [31:0] last_data;
    logic [1:0]  last_level;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic load(input logic [31:0] w);
        fifo.push_back(w);
        sent.push_back(w);
    endtask

    // One cycle: entered and left #1 after a rising edge.
    task automatic tick(input bit rdy);
        bit e_pop, e_rinc;
        int used;
        out_ready = rdy;
        rempty    = (fifo.size() == 0);
        #1;
        e_pop  = (mbuf.size() != 0) && rdy;
        used   = mbuf.size() + int'(m_infl) - int'(e_pop);
        e_rinc = !rempty && (used < 2);
        last_rinc  = rinc;
        last_valid = out_valid;
        last_data  = out_data;
        last_level = out_level;
        chk("valid", 32'(out_valid), 32'(mbuf.size() != 0));
        chk("level", 32'(out_level), 32'(mbuf.size()));
        if (mbuf.size() != 0) chk("data", out_data, mbuf[0]);
        chk("rinc", 32'(rinc), 32'(e_rinc));
        if (e_pop && sent.size() != 0) chk("order", out_data, sent.pop_front());
        @(posedge r_clk);
        #1;
        if (e_pop) void'(mbuf.pop_front());
        if (m_infl) mbuf.push_back(r_data);
        m_infl = e_rinc;
        r_data = e_rinc ? fifo.pop_front() : $urandom();
    endtask

    // Asynchronous reset assertion mid-cycle; outputs must clear without a clock.
    task automatic do_reset();
        rrst_n = 1'b0;
        rempty = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data,       32'd0);
        chk("rst_level", 32'(out_level), 32'd0);
        chk("rst_rinc",  32'(rinc),      32'd0);
        fifo.delete();
        sent.delete();
        mbuf.delete();
        m_infl = 1'b0;
        r_data = '0;
        repeat (2) @(posedge r_clk);
        #1;
    endtask

    initial begin
        rrst_n    = 1'b0;
        rempty    = 1'b1;
        out_ready = 1'b0;
        r_data    = '0;
        m_infl    = 1'b0;
        @(posedge r_clk);
        #1;
        do_reset();

        // Preloaded FIFO, first words after reset release.
        for (int i = 0; i < 4; i++) load(32'hA0 + 32'(i));
        rrst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(1'b1);
            chk("pre_rinc", 32'(last_rinc), 32'(c <= 3));
            chk("pre_valid", 32'(last_valid), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) chk("pre_data", last_data, 32'hA0 + 32'(c - 2));
        end

        // Continuous stream: level steady at 1, no bubbles.
        for (int i = 0; i < 16; i++) load(32'h100 + 32'(i));
        for (int c = 0; c < 20; c++) begin
            tick(1'b1);
            if (c >= 2 && c <= 17) chk("stream_level", 32'(last_level), 32'd1);
        end

        // Stall for 5 cycles mid-stream.
        for (int i = 0; i < 12; i++) load(32'h200 + 32'(i));
        for (int c = 0; c < 4; c++) tick(1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0);
            chk("stall_rinc", 32'(last_rinc), 32'd0);
        end
        chk("stall_level", 32'(last_level), 32'd2);
        for (int c = 0; c < 20; c++) tick(1'b1);
        chk("stall_drained", 32'(last_valid), 32'd0);

        // FIFO empties while out_ready toggles.
        for (int i = 0; i < 3; i++) load(32'h300 + 32'(i));
        for (int c = 0; c < 12; c++) tick(c[0] == 1'b0);
        chk("toggle_drained", 32'(last_valid), 32'd0);

        // Reset with a full buffer, then first-word latency again.
        for (int i = 0; i < 10; i++) load(32'h400 + 32'(i));
        for (int c = 0; c < 3; c++) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        chk("full_before_rst", 32'(last_level), 32'd2);
        do_reset();
        load(32'hC0);
        load(32'hC1);
        rrst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1'b1);
            chk("rr_valid", 32'(last_valid), 32'(c == 2 || c == 3));
            if (c == 0) chk("rr_rinc", 32'(last_rinc), 32'd1);
            if (c == 2) chk("rr_data0", last_data, 32'hC0);
            if (c == 3) chk("rr_data1", last_data, 32'hC1);
        end

        // Randomized producer fill and downstream readiness.
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 2) == 0 && fifo.size() < 6) load($urandom());
            tick($urandom_range(0, 9) < 7);
        end
        for (int c = 0; c < 20; c++) tick(1'b1);
        chk("final_sent_empty", 32'(sent.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
